readout_integrator: RTL and testbench

Receive-side counterpart to the pulse-scheduler → DAC AXI-Stream path. Consumes the ADC AXI-Stream of packed I/Q samples. For each measurement descriptor issued by the core, it integrates a fixed number of samples on both channels and thresholds the I integral to produce a qubit state bit. It presents the result on a valid/ready port toward the core-side result FIFO.

---
 rtl/readout_pkg.sv | 31 +++
 rtl/readout_if.sv | 40 ++++
 rtl/readout_accum.sv | 57 +++++
 rtl/readout_integrator.sv | 132 +++++++++++++
 tb/tb_readout_integrator.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/readout_pkg.sv
// Shared types and default widths for the readout integrator.
// Provides the FSM state enum, descriptor/result record types and default widths.
// The record types are sized by the default widths below.
package readout_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_TAG_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } readout_state_t;

  typedef struct packed {
    logic [DEF_LEN_W-1:0] len;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_ACC_W-1:0] thresh;
  } meas_descriptor_t;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic                 state_bit;
    logic [DEF_ACC_W-1:0] acc_i;
    logic [DEF_ACC_W-1:0] acc_q;
  } readout_result_t;

endpackage

// File: rtl/readout_if.sv
// Bundle of the descriptor, ADC sample stream and result ports of the integrator.
// slave: the integrator side (takes descriptors and samples, drives results).
// master: the core/ADC side (drives descriptors and samples, consumes results).
interface readout_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 16,
  parameter int TAG_W  = 4
);
  logic                     meas_valid;
  logic                     meas_ready;
  logic [LEN_W-1:0]         meas_len;
  logic [TAG_W-1:0]         meas_tag;
  logic signed [ACC_W-1:0]  meas_thresh;

  logic [2*DATA_W-1:0]      s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;

  logic                     res_valid;
  logic                     res_ready;
  logic [TAG_W-1:0]         res_tag;
  logic                     res_bit;
  logic signed [ACC_W-1:0]  res_acc_i;
  logic signed [ACC_W-1:0]  res_acc_q;

  modport slave (
    input  meas_valid, meas_len, meas_tag, meas_thresh,
    input  s_axis_tdata, s_axis_tvalid, res_ready,
    output meas_ready, s_axis_tready,
    output res_valid, res_tag, res_bit, res_acc_i, res_acc_q
  );

  modport master (
    output meas_valid, meas_len, meas_tag, meas_thresh,
    output s_axis_tdata, s_axis_tvalid, res_ready,
    input  meas_ready, s_axis_tready,
    input  res_valid, res_tag, res_bit, res_acc_i, res_acc_q
  );
endinterface

// File: rtl/readout_accum.sv
// One signed integration channel: clear, add-on-enable, one-cycle update.
// Ports: clk, rst (async high), clr_i, en_i, sample_i (signed DATA_W), acc_o (signed ACC_W).
// Macro READOUT_SAT_EN: saturate each add to the signed ACC_W range; otherwise wrap.
module readout_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sum_w;

`ifdef READOUT_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit is enough: the sample is never wider than the accumulator.
  logic signed [ACC_W:0] wide_w;
  assign wide_w = (ACC_W+1)'(acc_q) + (ACC_W+1)'(sample_i);

  always_comb begin
    sum_w = wide_w[ACC_W-1:0];
    if (wide_w[ACC_W] != wide_w[ACC_W-1]) begin
      sum_w = wide_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  assign sum_w = acc_q + ACC_W'(sample_i);
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/readout_integrator.sv
// Integrates len I/Q samples per measurement descriptor and thresholds the I sum.
// Ports: clk, rst (async high), bus (readout_if.slave: descriptor, ADC stream, result).
// Macro READOUT_SAT_EN: saturating accumulators (passed through to readout_accum).
module readout_integrator
  import readout_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic     clk,
  input  logic     rst,
  readout_if.slave bus
);

  readout_state_t          state_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt_q;
  logic [LEN_W-1:0]        cnt_d;
  logic [TAG_W-1:0]        tag_q;
  logic signed [ACC_W-1:0] thresh_q;

  logic                    meas_ready_q;
  logic                    tready_q;
  logic                    res_valid_q;
  logic [TAG_W-1:0]        res_tag_q;
  logic                    res_bit_q;
  logic signed [ACC_W-1:0] res_acc_i_q;
  logic signed [ACC_W-1:0] res_acc_q_q;

  logic                    samp_hs;
  logic                    acc_clr;
  logic                    acc_en;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;

  assign samp_hs = bus.s_axis_tvalid & tready_q;
  // Samples seen in IDLE (including the descriptor cycle) are flushed, never added.
  assign acc_clr = (state_q == IDLE) && bus.meas_valid;
  assign acc_en  = (state_q == ACCUM) && samp_hs;
  assign cnt_d   = cnt_q + LEN_W'(1);

  readout_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc_i (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .sample_i (bus.s_axis_tdata[DATA_W-1:0]),
    .acc_o    (acc_i)
  );

  readout_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc_q (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .sample_i (bus.s_axis_tdata[2*DATA_W-1:DATA_W]),
    .acc_o    (acc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      tag_q        <= '0;
      thresh_q     <= '0;
      meas_ready_q <= 1'b1;
      tready_q     <= 1'b1;
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_bit_q    <= 1'b0;
      res_acc_i_q  <= '0;
      res_acc_q_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.meas_valid) begin
            len_q        <= bus.meas_len;
            tag_q        <= bus.meas_tag;
            thresh_q     <= bus.meas_thresh;
            cnt_q        <= '0;
            meas_ready_q <= 1'b0;
            if (bus.meas_len != '0) begin
              state_q <= ACCUM;
            end else begin
              state_q  <= DECIDE;
              tready_q <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (samp_hs) begin
            cnt_q <= cnt_d;
            if (cnt_q == len_q - LEN_W'(1)) begin
              state_q  <= DECIDE;
              tready_q <= 1'b0;
            end
          end
        end
        DECIDE: begin
          // Accumulators already hold the last sample here.
          res_bit_q   <= (acc_i >= thresh_q);
          res_acc_i_q <= acc_i;
          res_acc_q_q <= acc_q;
          res_tag_q   <= tag_q;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q  <= 1'b0;
            meas_ready_q <= 1'b1;
            tready_q     <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.meas_ready    = meas_ready_q;
  assign bus.s_axis_tready = tready_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_tag       = res_tag_q;
  assign bus.res_bit       = res_bit_q;
  assign bus.res_acc_i     = res_acc_i_q;
  assign bus.res_acc_q     = res_acc_q_q;

endmodule

// File: tb/tb_readout_integrator.sv
// Directed bench for readout_integrator: vector table plus corner-case sequences.
// Instantiates a default-width DUT and a 17-bit accumulator DUT for the overflow case.
// Honours READOUT_SAT_EN when computing the overflow expectation.
module tb_readout_integrator;
  import readout_pkg::*;

  logic clk;
  logic rst;

  readout_if #(.DATA_W(16), .ACC_W(32), .LEN_W(16), .TAG_W(4)) bus ();
  readout_if #(.DATA_W(16), .ACC_W(17), .LEN_W(16), .TAG_W(4)) bus2 ();

  readout_integrator #(.DATA_W(16), .ACC_W(32), .LEN_W(16), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  readout_integrator #(.DATA_W(16), .ACC_W(17), .LEN_W(16), .TAG_W(4)) dut_ovf (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    meas_descriptor_t  d;
    logic [7:0][15:0]  i_s;
    logic [7:0][15:0]  q_s;
    readout_result_t   exp;
  } vec_t;

  vec_t vecs [8];
  int   checks;
  int   failures;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void set_vec(input int k, input int len, input int tag, input int thr,
                                  input int ai, input int aq, input bit b);
    vecs[k].d.len         = 16'(len);
    vecs[k].d.tag         = 4'(tag);
    vecs[k].d.thresh      = 32'(thr);
    vecs[k].exp.tag       = 4'(tag);
    vecs[k].exp.state_bit = b;
    vecs[k].exp.acc_i     = 32'(ai);
    vecs[k].exp.acc_q     = 32'(aq);
    vecs[k].i_s           = '0;
    vecs[k].q_s           = '0;
  endfunction

  function automatic void set_smp(input int k, input int j, input int i, input int q);
    vecs[k].i_s[j] = 16'(i);
    vecs[k].q_s[j] = 16'(q);
  endfunction

  task automatic chk_result(input string pfx, input vec_t v);
    chk({pfx, "_res_valid"}, longint'(bus.res_valid), 1);
    chk({pfx, "_res_tag"},   longint'(bus.res_tag), longint'(v.exp.tag));
    chk({pfx, "_res_bit"},   longint'(bus.res_bit), longint'(v.exp.state_bit));
    chk({pfx, "_acc_i"},     longint'(bus.res_acc_i), longint'($signed(v.exp.acc_i)));
    chk({pfx, "_acc_q"},     longint'(bus.res_acc_q), longint'($signed(v.exp.acc_q)));
  endtask

  // Runs one descriptor with len > 0. Inputs change on the falling edge, so each
  // falling-to-falling step spans exactly one handshake edge.
  task automatic run_vec(input int k, input bit gap, input int stall);
    vec_t v;
    int   len;
    v   = vecs[k];
    len = int'(v.d.len);
    @(negedge clk);
    chk("meas_ready_idle", longint'(bus.meas_ready), 1);
    bus.meas_valid  = 1'b1;
    bus.meas_len    = v.d.len;
    bus.meas_tag    = v.d.tag;
    bus.meas_thresh = v.d.thresh;
    @(negedge clk);
    bus.meas_valid = 1'b0;
    chk("meas_ready_busy", longint'(bus.meas_ready), 0);
    for (int j = 0; j < len; j++) begin
      if (gap && (j % 2 == 1)) begin
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = {v.q_s[j], v.i_s[j]};
      @(negedge clk);
    end
    bus.s_axis_tvalid = 1'b0;
    // Cycle S+1: DECIDE, nothing visible yet.
    chk("decide_res_valid", longint'(bus.res_valid), 0);
    chk("decide_tready", longint'(bus.s_axis_tready), 0);
    bus.res_ready = (stall == 0);
    @(negedge clk);
    chk_result("hold", v);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk_result("stall", v);
      chk("stall_meas_ready", longint'(bus.meas_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("post_meas_ready", longint'(bus.meas_ready), 1);
    chk("post_res_valid", longint'(bus.res_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint ovf_acc;
    longint ovf_bit;
    checks   = 0;
    failures = 0;

    bus.meas_valid = 1'b0; bus.meas_len = '0; bus.meas_tag = '0; bus.meas_thresh = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.res_ready = 1'b1;
    bus2.meas_valid = 1'b0; bus2.meas_len = '0; bus2.meas_tag = '0; bus2.meas_thresh = '0;
    bus2.s_axis_tdata = '0; bus2.s_axis_tvalid = 1'b0; bus2.res_ready = 1'b1;

    set_vec(0, 4, 1, 0, 400, -20, 1'b1);
    for (int j = 0; j < 4; j++) set_smp(0, j, 100, -5);
    set_vec(1, 3, 2, 10, 9, 6, 1'b0);
    set_smp(1, 0, 5, 1); set_smp(1, 1, 2, 2); set_smp(1, 2, 2, 3);
    set_vec(2, 3, 2, 9, 9, 6, 1'b1);
    set_smp(2, 0, 5, 1); set_smp(2, 1, 2, 2); set_smp(2, 2, 2, 3);
    set_vec(3, 1, 3, -1, -1, 7, 1'b1);
    set_smp(3, 0, -1, 7);
    set_vec(4, 2, 4, -5, -6, -65536, 1'b0);
    for (int j = 0; j < 2; j++) set_smp(4, j, -3, -32768);
    set_vec(5, 8, 15, 100000, 262136, -8, 1'b1);
    for (int j = 0; j < 8; j++) set_smp(5, j, 32767, -1);
    set_vec(6, 2, 5, 3, 2, 0, 1'b0);
    for (int j = 0; j < 2; j++) set_smp(6, j, 1, 0);
    set_vec(7, 5, 6, 0, 30, 15, 1'b1);
    set_smp(7, 0, 10, 1); set_smp(7, 1, -20, 2); set_smp(7, 2, 30, 3);
    set_smp(7, 3, -40, 4); set_smp(7, 4, 50, 5);

    // Reset values.
    rst = 1'b1;
    #12;
    chk("rst_meas_ready", longint'(bus.meas_ready), 1);
    chk("rst_tready", longint'(bus.s_axis_tready), 1);
    chk("rst_res_valid", longint'(bus.res_valid), 0);
    chk("rst_res_tag", longint'(bus.res_tag), 0);
    chk("rst_res_bit", longint'(bus.res_bit), 0);
    chk("rst_acc_i", longint'(bus.res_acc_i), 0);
    chk("rst_acc_q", longint'(bus.res_acc_q), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table: back-to-back samples, consumer always ready.
    for (int k = 0; k < 6; k++) run_vec(k, 1'b0, 0);

    // Gapped samples and a 4-cycle result stall.
    run_vec(7, 1'b1, 4);

    // Idle flush, then len=0 accepted while samples keep arriving.
    bus.s_axis_tdata = {16'sd300, 16'sd500};
    bus.s_axis_tvalid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("flush_tready", longint'(bus.s_axis_tready), 1);
    end
    bus.meas_valid = 1'b1; bus.meas_len = '0; bus.meas_tag = 4'd7; bus.meas_thresh = '0;
    @(negedge clk);
    bus.meas_valid = 1'b0;
    chk("len0_t1_res_valid", longint'(bus.res_valid), 0);
    chk("len0_t1_tready", longint'(bus.s_axis_tready), 0);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    chk("len0_res_valid", longint'(bus.res_valid), 1);
    chk("len0_acc_i", longint'(bus.res_acc_i), 0);
    chk("len0_acc_q", longint'(bus.res_acc_q), 0);
    chk("len0_res_bit", longint'(bus.res_bit), 1);
    chk("len0_res_tag", longint'(bus.res_tag), 7);
    @(negedge clk);
    chk("len0_post_meas_ready", longint'(bus.meas_ready), 1);

    // Reset in the middle of ACCUM after 2 of 8 samples.
    @(negedge clk);
    bus.meas_valid = 1'b1; bus.meas_len = 16'd8; bus.meas_tag = 4'd9; bus.meas_thresh = '0;
    @(negedge clk);
    bus.meas_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = {16'sd50, 16'sd50};
      @(negedge clk);
    end
    bus.s_axis_tvalid = 1'b0;
    chk("pre_rst_meas_ready", longint'(bus.meas_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_meas_ready", longint'(bus.meas_ready), 1);
    chk("mid_rst_res_valid", longint'(bus.res_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("post_rst_no_result", longint'(bus.res_valid), 0);
    end
    run_vec(6, 1'b0, 0);

    // Overflow on the 17-bit accumulator instance.
`ifdef READOUT_SAT_EN
    ovf_acc = 65535;
    ovf_bit = 1;
`else
    ovf_acc = -4;
    ovf_bit = 0;
`endif
    @(negedge clk);
    bus2.meas_valid = 1'b1; bus2.meas_len = 16'd4; bus2.meas_tag = 4'd10; bus2.meas_thresh = '0;
    @(negedge clk);
    bus2.meas_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus2.s_axis_tvalid = 1'b1;
      bus2.s_axis_tdata  = {16'h0000, 16'h7fff};
      @(negedge clk);
    end
    bus2.s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("ovf_res_valid", longint'(bus2.res_valid), 1);
    chk("ovf_acc_i", longint'(bus2.res_acc_i), ovf_acc);
    chk("ovf_acc_q", longint'(bus2.res_acc_q), 0);
    chk("ovf_res_bit", longint'(bus2.res_bit), ovf_bit);
    @(negedge clk);
    chk("ovf_post_meas_ready", longint'(bus2.meas_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
